ps2_receiver: RTL
=================

Name: ps2_receiver

Overview:
Receives PS/2 keyboard frames from the raw ps2Clk/ps2Data pins and returns one scan-code byte per valid frame. It sits directly upstream of the scan-code-to-ASCII key memory and drives that block's scanCode/scanCodeReady inputs. The block synchronizes and deglitches the pins, decodes the 11-bit frame, checks parity and stop bit, and recovers from truncated frames with a watchdog.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized ps2Clk samples required before the filtered clock changes level.
TIMEOUT_CYCLES, 50000, idle-clock cycles allowed mid-frame before abort (1 ms at 50 MHz); counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
ps2Clk  input  1  raw PS/2 clock pin (asynchronous)
ps2Data  input  1  raw PS/2 data pin (asynchronous)
scanCode  output  8  last correctly received byte
scanCodeReady  output  1  one-cycle pulse: scanCode holds a new byte
parityError  output  1  one-cycle pulse: frame dropped, odd-parity check failed
frameError  output  1  one-cycle pulse: frame dropped, bad stop bit or timeout
receiving  output  1  high while state != IDLE

Behaviour:
- One clock. Reset is synchronous and active-high; clock and reset ports are clk and rst.
- Reset: state=IDLE, scanCode=8'h00, scanCodeReady/parityError/frameError=0, receiving=0, shift register, bit counter, filter counter and timeout counter=0, filtered clock=1, synchronizer flops=1.
- Sync: ps2Clk and ps2Data each pass through a 2-flop synchronizer.
- Filter: the filtered clock takes the synchronized value only after FILTER_LEN consecutive equal samples that differ from its current level. Shorter pulses are ignored.
- fallEdge: one-cycle strobe when the filtered clock goes 1->0. The synchronized ps2Data is sampled in the fallEdge cycle.
- FSM states are IDLE, DATA, PARITY, STOP. All transitions occur only on fallEdge, except timeout.
  - IDLE: sampled bit 0 -> DATA, bitCount=0. Sampled bit 1 -> stay in IDLE with no error (spurious edge).
  - DATA: shift right with the new bit into [7], so bits arrive LSB first. After the 8th bit (bitCount==7) -> PARITY.
  - PARITY: store the bit; parityOk = ^{data, bit} == 1 (odd parity). -> STOP.
  - STOP: always returns to IDLE. The outcome depends on the sampled bit and parity:
    - bit==1 and parityOk: scanCode<=data and scanCodeReady=1 in the next cycle.
    - bit==1 and !parityOk: parityError pulse.
    - bit==0: frameError pulse. This takes precedence over the parity outcome.
- Latency: scanCodeReady rises on the clk edge following the stop-bit fallEdge cycle. It is high for exactly 1 cycle. scanCode is held until the next valid frame.
- Dropped frames never change scanCode and never pulse scanCodeReady.
- Timeout: the counter clears on every fallEdge and while in IDLE, otherwise it increments. If it reaches TIMEOUT_CYCLES outside IDLE: go to IDLE, frameError pulse, counter cleared. If a fallEdge and the timeout occur in the same cycle, the fallEdge wins.
- At most one of scanCodeReady/parityError/frameError is high in any cycle.
- rst asserted mid-frame: the partial frame is discarded and reset values apply on the next edge. A frame already in progress on the pins after rst deasserts is decoded from whatever edge follows. Mid-frame garbage is resolved by the stop-bit check or the timeout.
- Receive only: the block never drives the PS/2 pins.

Decomposition:
- Package ps2_pkg holds:
  - typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} Ps2RxState;
  - constants PS2_BREAK=8'hF0 and PS2_EXTENDED=8'hE0, shared with the downstream key memory;
  - PS2_FRAME_BITS=11.
- Sub-module ps2_input_filter holds the 2-flop sync, the FILTER_LEN debounce and the fall-edge strobe. It is instantiated for ps2Clk only; ps2Data uses a plain synchronizer.

Test Plan:
- Valid frame: drive 0x1C as start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, with a 2000-cycle half-period -> one scanCodeReady pulse, scanCode=8'h1C, no error pulses.
- Break sequence: frames 0xF0 (parity 1), then 0x1C -> two ready pulses with scanCode 8'hF0 then 8'h1C, receiving low between frames.
- Parity fault: 0x1C sent with parity 1 -> parityError pulse, no scanCodeReady, scanCode keeps its previous value. A following valid 0x29 (parity 0) -> scanCode=8'h29.
- Stop fault and glitch: 0x1C with stop 0 -> frameError only. A 3-cycle low glitch on ps2Clk in IDLE (less than FILTER_LEN) -> no state change, receiving stays 0.
- Timeout: TIMEOUT_CYCLES=5000, send start plus 3 data bits, then hold ps2Clk high -> frameError 5000 cycles after the last edge, receiving=0. A following valid 0x29 is received correctly.
- Reset mid-frame: assert rst for 1 cycle after 4 data bits -> all outputs and state reset. A subsequent full frame 0x45 (parity 0) -> scanCode=8'h45, ready pulse.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the receiver and the downstream scan-code key memory.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} Ps2RxState;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXTENDED   = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_input_filter.sv
// Synchronizes and debounces the raw PS/2 clock pin and strobes on each filtered falling edge.
module ps2_input_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic fall_edge
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;
  logic          differs;
  logic          settle;

  assign differs = sync[1] != level;
  assign settle  = differs && (cnt == CW'(FILTER_LEN - 1));

  // The strobe is registered so it lines up with the cycle the filtered level first reads low.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      level     <= 1'b1;
      cnt       <= '0;
      fall_edge <= 1'b0;
    end else begin
      sync      <= {sync[0], pin};
      fall_edge <= settle && level;
      if (settle) begin
        level <= sync[1];
        cnt   <= '0;
      end else if (differs) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard frame receiver: decodes 11-bit frames into scan codes with parity, stop-bit and watchdog checks.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [7:0] scanCode,
  output logic       scanCodeReady,
  output logic       parityError,
  output logic       frameError,
  output logic       receiving
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  Ps2RxState      state, state_n;
  logic [1:0]     data_sync;
  logic           data_bit;
  logic           fall;
  logic [7:0]     shreg, shreg_n;
  logic [2:0]     bit_cnt, bit_cnt_n;
  logic           par_bit, par_n;
  logic [TW-1:0]  tcnt, tcnt_n;
  logic [7:0]     code_n;
  logic           ready_n, perr_n, ferr_n;

  ps2_input_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk       (clk),
    .rst       (rst),
    .pin       (ps2Clk),
    .fall_edge (fall)
  );

  // Data is only sampled long after it settles, so a plain synchronizer suffices.
  assign data_bit  = data_sync[1];
  assign receiving = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      data_sync     <= 2'b11;
      shreg         <= '0;
      bit_cnt       <= '0;
      par_bit       <= 1'b0;
      tcnt          <= '0;
      scanCode      <= 8'h00;
      scanCodeReady <= 1'b0;
      parityError   <= 1'b0;
      frameError    <= 1'b0;
    end else begin
      state         <= state_n;
      data_sync     <= {data_sync[0], ps2Data};
      shreg         <= shreg_n;
      bit_cnt       <= bit_cnt_n;
      par_bit       <= par_n;
      tcnt          <= tcnt_n;
      scanCode      <= code_n;
      scanCodeReady <= ready_n;
      parityError   <= perr_n;
      frameError    <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_n     = par_bit;
    code_n    = scanCode;
    ready_n   = 1'b0;
    perr_n    = 1'b0;
    ferr_n    = 1'b0;
    tcnt_n    = (fall || state == IDLE) ? '0 : tcnt + 1'b1;
    if (fall) begin
      unique case (state)
        IDLE: begin
          // A high bit here is a stray edge, not a start bit; ignore it silently.
          if (!data_bit) begin
            state_n   = DATA;
            bit_cnt_n = '0;
          end
        end
        DATA: begin
          shreg_n   = {data_bit, shreg[7:1]};
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_n   = data_bit;
          state_n = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!data_bit) begin
            ferr_n = 1'b1;
          end else if (odd_parity_ok(shreg, par_bit)) begin
            code_n  = shreg;
            ready_n = 1'b1;
          end else begin
            perr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && tcnt == TW'(TIMEOUT_CYCLES)) begin
      state_n = IDLE;
      ferr_n  = 1'b1;
      tcnt_n  = '0;
    end
  end

endmodule
